// File: rtl/bs_rr_arbtr_multi.sv
// bs_rr_arbtr_multi: BITS independent shared buses, each arbitrating DRVRS device FIFOs and
// delivering one packet per grant. Optional feature macro: BS_DROP_CNT_EN (per-bus drop counter).
module bs_rr_arbtr_multi #(
    parameter int         BITS      = 1,
    parameter int         DRVRS     = 4,
    parameter int         PCKG_SZ   = 16,
    parameter logic [7:0] BROADCAST = 8'hFF,
    parameter int         ARB_MODE  = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [BITS*DRVRS-1:0]           pndng,
    input  logic [BITS*DRVRS*PCKG_SZ-1:0]   D_pop,
    output logic [BITS*DRVRS-1:0]           pop,
    output logic [BITS*DRVRS-1:0]           push,
    output logic [BITS*PCKG_SZ-1:0]         D_push,
    output logic [BITS-1:0]                 busy,
    output logic [BITS-1:0]                 drop,
    output logic [BITS*2-1:0]               dbg_state
`ifdef BS_DROP_CNT_EN
    ,
    output logic [BITS*16-1:0]              drop_cnt
`endif
);

    localparam int IDX_W = $clog2(DRVRS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    // Round-robin searches upward from ptr with wrap; fixed priority searches from index 0.
    function automatic logic [IDX_W-1:0] pick(input logic [DRVRS-1:0] req,
                                              input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] res;
        int               idx;
        found = 1'b0;
        res   = '0;
        for (int i = 0; i < DRVRS; i++) begin
            idx = (ARB_MODE == 1) ? i : (int'(ptr) + i) % DRVRS;
            if (!found && req[IDX_W'(idx)]) begin
                found = 1'b1;
                res   = IDX_W'(idx);
            end
        end
        return res;
    endfunction

    for (genvar b = 0; b < BITS; b++) begin : g_bus
        state_t             state_q, state_d;
        logic [IDX_W-1:0]   ptr_q, ptr_d;
        logic [IDX_W-1:0]   win_q, win_d;
        logic [PCKG_SZ-1:0] pkt_q, pkt_d;
        logic [PCKG_SZ-1:0] head;
        logic [DRVRS-1:0]   req;
        logic [DRVRS-1:0]   pop_c;
        logic [DRVRS-1:0]   push_q, push_d;
        logic               drop_q, drop_d;
        logic [7:0]         dest;

        assign req = pndng[b*DRVRS +: DRVRS];

        always_comb begin
            head = '0;
            for (int d = 0; d < DRVRS; d++) begin
                if (win_q == IDX_W'(d)) head = D_pop[(b*DRVRS+d)*PCKG_SZ +: PCKG_SZ];
            end
        end

        assign dest = head[PCKG_SZ-1 -: 8];

        // Handshake: pndng is a level "head valid"; pop is the one-cycle ready strobe, and the
        // FIFO advances on the rising edge that ends a cycle with both pndng and pop high.
        always_comb begin
            state_d = state_q;
            ptr_d   = ptr_q;
            win_d   = win_q;
            pkt_d   = pkt_q;
            push_d  = '0;
            drop_d  = 1'b0;
            pop_c   = '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        win_d   = pick(req, ptr_q);
                        state_d = GRANT;
                    end
                end
                GRANT: begin
                    if (req[win_q]) begin
                        pop_c[win_q] = 1'b1;
                        pkt_d        = head;
                        state_d      = DELIVER;
                        ptr_d        = (win_q == IDX_W'(DRVRS-1)) ? '0 : win_q + IDX_W'(1);
                        if (dest == BROADCAST) begin
                            push_d        = '1;
                            push_d[win_q] = 1'b0;
                        end else if (int'(dest) < DRVRS) begin
                            push_d[dest[IDX_W-1:0]] = 1'b1;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                ptr_q   <= '0;
                win_q   <= '0;
                pkt_q   <= '0;
                push_q  <= '0;
                drop_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                win_q   <= win_d;
                pkt_q   <= pkt_d;
                push_q  <= push_d;
                drop_q  <= drop_d;
            end
        end

        assign pop[b*DRVRS +: DRVRS]      = pop_c;
        assign push[b*DRVRS +: DRVRS]     = push_q;
        assign D_push[b*PCKG_SZ +: PCKG_SZ] = pkt_q;
        assign busy[b]                    = (state_q != IDLE);
        assign drop[b]                    = drop_q;
        assign dbg_state[b*2 +: 2]        = state_q;

`ifdef BS_DROP_CNT_EN
        logic [15:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (drop_d && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign drop_cnt[b*16 +: 16] = cnt_q;
`endif
    end

endmodule

// File: tb/tb_bs_rr_arbtr_multi.sv
// Directed bench for bs_rr_arbtr_multi: a two-bus round-robin instance and a one-bus
// fixed-priority instance, each scenario in its own task with inline checks.
`timescale 1ns/1ps
module tb_bs_rr_arbtr_multi;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic [7:0]   pndng_a;
    logic [127:0] dpop_a;
    logic [7:0]   pop_a, push_a;
    logic [31:0]  dpush_a;
    logic [1:0]   busy_a, drop_a;
    logic [3:0]   dbg_a;

    logic [3:0]   pndng_f;
    logic [63:0]  dpop_f;
    logic [3:0]   pop_f, push_f;
    logic [15:0]  dpush_f;
    logic         busy_f, drop_f;
    logic [1:0]   dbg_f;

`ifdef BS_DROP_CNT_EN
    logic [31:0]  dcnt_a;
    logic [15:0]  dcnt_f;
`endif

    int errors = 0;
    int checks = 0;

    bs_rr_arbtr_multi #(.BITS(2), .DRVRS(4), .PCKG_SZ(16), .BROADCAST(8'hFF), .ARB_MODE(0)) dut_a (
        .clk      (clk),
        .reset    (rst_n),
        .pndng    (pndng_a),
        .D_pop    (dpop_a),
        .pop      (pop_a),
        .push     (push_a),
        .D_push   (dpush_a),
        .busy     (busy_a),
        .drop     (drop_a),
        .dbg_state(dbg_a)
`ifdef BS_DROP_CNT_EN
        ,
        .drop_cnt (dcnt_a)
`endif
    );

    bs_rr_arbtr_multi #(.BITS(1), .DRVRS(4), .PCKG_SZ(16), .BROADCAST(8'hFF), .ARB_MODE(1)) dut_f (
        .clk      (clk),
        .reset    (rst_n),
        .pndng    (pndng_f),
        .D_pop    (dpop_f),
        .pop      (pop_f),
        .push     (push_f),
        .D_push   (dpush_f),
        .busy     (busy_f),
        .drop     (drop_f),
        .dbg_state(dbg_f)
`ifdef BS_DROP_CNT_EN
        ,
        .drop_cnt (dcnt_f)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_a(input int dev, input logic [15:0] pkt);
        dpop_a[dev*16 +: 16] = pkt;
        pndng_a[dev]         = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        pndng_a = '0;
        dpop_a  = '0;
        pndng_f = '0;
        dpop_f  = '0;
        tick();
        tick();
        checks++; if (pop_a !== 8'h00 || pop_f !== 4'h0) begin errors++; $display("FAIL reset_pop: a=%h f=%h expected 0", pop_a, pop_f); end
        checks++; if (push_a !== 8'h00 || push_f !== 4'h0) begin errors++; $display("FAIL reset_push: a=%h f=%h expected 0", push_a, push_f); end
        checks++; if (dpush_a !== 32'h0 || dpush_f !== 16'h0) begin errors++; $display("FAIL reset_dpush: a=%h f=%h expected 0", dpush_a, dpush_f); end
        checks++; if (busy_a !== 2'b00 || busy_f !== 1'b0) begin errors++; $display("FAIL reset_busy: a=%b f=%b expected 0", busy_a, busy_f); end
        checks++; if (drop_a !== 2'b00 || drop_f !== 1'b0) begin errors++; $display("FAIL reset_drop: a=%b f=%b expected 0", drop_a, drop_f); end
`ifdef BS_DROP_CNT_EN
        checks++; if (dcnt_a !== 32'h0) begin errors++; $display("FAIL reset_drop_cnt: got %h expected 0", dcnt_a); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rr_order();
        logic [3:0] exp_q[$];
        logic [3:0] exp_v;
        logic [3:0] got;
        int         cnt;
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int d = 0; d < 4; d++) dpop_a[d*16 +: 16] = 16'h0100;
        pndng_a[3:0] = 4'hF;
        for (int g = 0; g < 5; g++) begin
            cnt = 0;
            do begin tick(); cnt++; end while (pop_a[3:0] == 4'b0000 && cnt < 8);
            got   = pop_a[3:0];
            exp_v = exp_q.pop_front();
            checks++; if (got !== exp_v) begin errors++; $display("FAIL rr_order[%0d]: pop=%b expected %b", g, got, exp_v); end
            checks++; if (cnt !== ((g == 0) ? 1 : 3)) begin errors++; $display("FAIL rr_spacing[%0d]: cycles=%0d expected %0d", g, cnt, (g == 0) ? 1 : 3); end
        end
        tick();
        pndng_a[3:0] = 4'h0;
        tick();
    endtask

    task automatic test_fp_order();
        int cnt;
        for (int d = 0; d < 4; d++) dpop_f[d*16 +: 16] = 16'h0100;
        pndng_f = 4'hF;
        for (int g = 0; g < 5; g++) begin
            cnt = 0;
            do begin tick(); cnt++; end while (pop_f == 4'b0000 && cnt < 8);
            checks++; if (pop_f !== 4'b0001) begin errors++; $display("FAIL fp_order[%0d]: pop=%b expected 0001", g, pop_f); end
        end
        tick();
        pndng_f = 4'h0;
        tick();
    endtask

    task automatic test_unicast();
        load_a(1, 16'h02AB);
        checks++; if (pop_a !== 8'h00) begin errors++; $display("FAIL uni_idle_pop: got %h expected 00", pop_a); end
        tick();
        checks++; if (pop_a !== 8'h02) begin errors++; $display("FAIL uni_pop: got %h expected 02", pop_a); end
        checks++; if (dbg_a[1:0] !== 2'd1 || busy_a !== 2'b01) begin errors++; $display("FAIL uni_grant_state: dbg=%0d busy=%b expected 1/01", dbg_a[1:0], busy_a); end
        tick();
        checks++; if (push_a !== 8'h04) begin errors++; $display("FAIL uni_push: got %h expected 04", push_a); end
        checks++; if (dpush_a[15:0] !== 16'h02AB) begin errors++; $display("FAIL uni_dpush: got %h expected 02ab", dpush_a[15:0]); end
        checks++; if (pop_a !== 8'h00 || drop_a !== 2'b00) begin errors++; $display("FAIL uni_deliver_misc: pop=%h drop=%b expected 00/00", pop_a, drop_a); end
        pndng_a[1] = 1'b0;
        tick();
        checks++; if (push_a !== 8'h00 || busy_a !== 2'b00) begin errors++; $display("FAIL uni_idle_after: push=%h busy=%b expected 00/00", push_a, busy_a); end
        checks++; if (dpush_a[15:0] !== 16'h02AB) begin errors++; $display("FAIL uni_dpush_hold: got %h expected 02ab", dpush_a[15:0]); end
    endtask

    task automatic test_broadcast();
        load_a(3, 16'hFF55);
        tick();
        checks++; if (pop_a !== 8'h08) begin errors++; $display("FAIL bc_pop: got %h expected 08", pop_a); end
        tick();
        checks++; if (push_a !== 8'h07) begin errors++; $display("FAIL bc_push: got %h expected 07", push_a); end
        checks++; if (dpush_a[15:0] !== 16'hFF55 || drop_a !== 2'b00) begin errors++; $display("FAIL bc_data: dpush=%h drop=%b expected ff55/00", dpush_a[15:0], drop_a); end
        pndng_a[3] = 1'b0;
        tick();
    endtask

    task automatic test_drop();
        load_a(0, 16'h0912);
        tick();
        checks++; if (pop_a !== 8'h01) begin errors++; $display("FAIL drop_pop: got %h expected 01", pop_a); end
        tick();
        checks++; if (push_a !== 8'h00 || drop_a !== 2'b01) begin errors++; $display("FAIL drop_pulse: push=%h drop=%b expected 00/01", push_a, drop_a); end
        checks++; if (dpush_a[15:0] !== 16'h0912) begin errors++; $display("FAIL drop_dpush: got %h expected 0912", dpush_a[15:0]); end
`ifdef BS_DROP_CNT_EN
        checks++; if (dcnt_a !== 32'h0000_0001) begin errors++; $display("FAIL drop_cnt: got %h expected 00000001", dcnt_a); end
`endif
        pndng_a[0] = 1'b0;
        tick();
        checks++; if (drop_a !== 2'b00 || push_a !== 8'h00) begin errors++; $display("FAIL drop_one_cycle: drop=%b push=%h expected 00/00", drop_a, push_a); end
    endtask

    task automatic test_two_bus();
        load_a(2, 16'h0133);
        load_a(4, 16'h0344);
        tick();
        checks++; if (pop_a !== 8'h14) begin errors++; $display("FAIL two_bus_pop: got %h expected 14", pop_a); end
        checks++; if (busy_a !== 2'b11) begin errors++; $display("FAIL two_bus_busy: got %b expected 11", busy_a); end
        tick();
        checks++; if (push_a !== 8'h82) begin errors++; $display("FAIL two_bus_push: got %h expected 82", push_a); end
        checks++; if (dpush_a !== 32'h0344_0133) begin errors++; $display("FAIL two_bus_dpush: got %h expected 03440133", dpush_a); end
        pndng_a = '0;
        tick();
    endtask

    task automatic test_reset_in_deliver();
        load_a(1, 16'h0255);
        tick();
        tick();
        checks++; if (push_a !== 8'h04) begin errors++; $display("FAIL rst_pre_push: got %h expected 04", push_a); end
        #1;
        rst_n   = 1'b0;
        pndng_a = '0;
        #1;
        checks++; if (push_a !== 8'h00 || busy_a !== 2'b00) begin errors++; $display("FAIL rst_async_clear: push=%h busy=%b expected 00/00", push_a, busy_a); end
        checks++; if (dpush_a !== 32'h0) begin errors++; $display("FAIL rst_dpush_clear: got %h expected 0", dpush_a); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (push_a !== 8'h00 || pop_a !== 8'h00) begin errors++; $display("FAIL rst_quiet[%0d]: push=%h pop=%h expected 00/00", i, push_a, pop_a); end
        end
        load_a(0, 16'h0300);
        load_a(2, 16'h0100);
        tick();
        checks++; if (pop_a !== 8'h01) begin errors++; $display("FAIL rst_ptr_zero: pop=%h expected 01", pop_a); end
        tick();
        checks++; if (push_a !== 8'h08) begin errors++; $display("FAIL rst_next_push: got %h expected 08", push_a); end
        pndng_a = '0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rr_order();
        test_fp_order();
        test_unicast();
        test_broadcast();
        test_drop();
        test_two_bus();
        test_reset_in_deliver();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
